// File: rtl/voltage_droop_monitor.sv
// Per-SM droop front-end: window-averages sensor samples into a saturated 8-bit voltage code.
// Optional peak-hold blending is enabled by defining VDM_PEAK_HOLD_EN.
module voltage_droop_monitor #(
  parameter int unsigned WINDOW      = 20,
  parameter int unsigned VOLT_MAX    = 199,
  parameter int unsigned PEAK_MARGIN = 40
) (
  input  logic       clk_sm,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       epoch_sync,
  output logic [7:0] SM_voltage,
  output logic       voltage_valid,
  output logic       stale
);

  if (WINDOW < 2 || WINDOW > 32 || VOLT_MAX > 255 || PEAK_MARGIN > 255) begin : g_bad_params
    $error("voltage_droop_monitor: parameter out of range");
  end

  localparam logic [4:0]  LAST_POS = 5'(WINDOW - 1);
  localparam logic [12:0] WIN_DIV  = 13'(WINDOW);
  localparam logic [12:0] VMAX13   = 13'(VOLT_MAX);

  logic [4:0]  cnt_q, cnt_d;
  logic [12:0] acc_q, acc_d;
  logic [7:0]  held_q, held_d;
  logic        seen_q, seen_d;
  logic [7:0]  volt_q, volt_d;
  logic        vvalid_q, vvalid_d;
  logic        stale_q, stale_d;

  logic [7:0]  eff;
  logic [12:0] total;
  logic [12:0] avg;
  logic [12:0] pick;
  logic [7:0]  pubVal;
  logic        lastPos;
  logic        anyValid;

  // Zero-order hold: an invalid cycle repeats the last valid sensor code.
  assign eff      = sample_valid ? sample : held_q;
  assign total    = acc_q + {5'b0, eff};
  assign avg      = total / WIN_DIV;
  assign lastPos  = (cnt_q == LAST_POS);
  assign anyValid = seen_q | sample_valid;

`ifdef VDM_PEAK_HOLD_EN
  localparam logic [7:0] MARGIN8 = 8'(PEAK_MARGIN);

  logic [7:0]  peak_q, peak_d;
  logic [7:0]  peakMax;
  logic [12:0] peakFloor;

  assign peakMax   = (eff > peak_q) ? eff : peak_q;
  assign peakFloor = (peakMax > MARGIN8) ? {5'b0, peakMax - MARGIN8} : 13'd0;
  assign pick      = (peakFloor > avg) ? peakFloor : avg;
`else
  assign pick = avg;
`endif

  assign pubVal = (pick > VMAX13) ? VMAX13[7:0] : pick[7:0];

  always_comb begin
    held_d   = sample_valid ? sample : held_q;
    vvalid_d = 1'b0;
    volt_d   = volt_q;
    stale_d  = stale_q;
    cnt_d    = cnt_q + 5'd1;
    acc_d    = total;
    seen_d   = anyValid;
`ifdef VDM_PEAK_HOLD_EN
    peak_d   = peakMax;
`endif
    // A sync restart discards the partial window, even when it lands on the final cycle.
    if (epoch_sync) begin
      cnt_d  = 5'd0;
      acc_d  = 13'd0;
      seen_d = 1'b0;
`ifdef VDM_PEAK_HOLD_EN
      peak_d = 8'd0;
`endif
    end else if (lastPos) begin
      cnt_d    = 5'd0;
      acc_d    = 13'd0;
      seen_d   = 1'b0;
`ifdef VDM_PEAK_HOLD_EN
      peak_d   = 8'd0;
`endif
      vvalid_d = 1'b1;
      stale_d  = ~anyValid;
      if (anyValid) begin
        volt_d = pubVal;
      end
    end
  end

  always_ff @(posedge clk_sm or posedge rst) begin
    if (rst) begin
      cnt_q    <= 5'd0;
      acc_q    <= 13'd0;
      held_q   <= 8'd0;
      seen_q   <= 1'b0;
      volt_q   <= 8'd0;
      vvalid_q <= 1'b0;
      stale_q  <= 1'b0;
`ifdef VDM_PEAK_HOLD_EN
      peak_q   <= 8'd0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      held_q   <= held_d;
      seen_q   <= seen_d;
      volt_q   <= volt_d;
      vvalid_q <= vvalid_d;
      stale_q  <= stale_d;
`ifdef VDM_PEAK_HOLD_EN
      peak_q   <= peak_d;
`endif
    end
  end

  assign SM_voltage    = volt_q;
  assign voltage_valid = vvalid_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_voltage_droop_monitor.sv
// Scoreboard bench for voltage_droop_monitor: a per-cycle reference model queues expected
// outputs as stimulus is driven, and a negedge monitor pops and compares them.
module tb_voltage_droop_monitor;

  localparam int WINDOW      = 20;
  localparam int VOLT_MAX    = 199;
  localparam int PEAK_MARGIN = 40;

  logic       clk_sm = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic       epoch_sync = 1'b0;
  logic [7:0] SM_voltage;
  logic       voltage_valid;
  logic       stale;

  int assertCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic       strobe;
    logic [7:0] volt;
    logic       stale;
  } exp_t;

  exp_t expQ[$];

  int mCnt, mAcc, mHeld, mPeak, mVolt;
  bit mSeen, mStale, mStrobe;

  voltage_droop_monitor #(
    .WINDOW(WINDOW),
    .VOLT_MAX(VOLT_MAX),
    .PEAK_MARGIN(PEAK_MARGIN)
  ) dut (
    .clk_sm(clk_sm),
    .rst(rst),
    .sample(sample),
    .sample_valid(sample_valid),
    .epoch_sync(epoch_sync),
    .SM_voltage(SM_voltage),
    .voltage_valid(voltage_valid),
    .stale(stale)
  );

  always #5 clk_sm = ~clk_sm;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: advances one clock and returns the expected post-edge outputs.
  task automatic modelStep(input bit r, input bit sv, input int s, input bit es);
    int eff, avg, pk;
    exp_t e;
    if (r) begin
      mCnt = 0; mAcc = 0; mHeld = 0; mPeak = 0; mVolt = 0;
      mSeen = 0; mStale = 0; mStrobe = 0;
    end else begin
      eff = sv ? s : mHeld;
      if (sv) mHeld = s;
      mStrobe = 0;
      if (es) begin
        mCnt = 0; mAcc = 0; mSeen = 0; mPeak = 0;
      end else begin
        mAcc = mAcc + eff;
        if (eff > mPeak) mPeak = eff;
        mSeen = mSeen | sv;
        if (mCnt == WINDOW - 1) begin
          mStrobe = 1;
          mStale = !mSeen;
          if (mSeen) begin
            avg = mAcc / WINDOW;
`ifdef VDM_PEAK_HOLD_EN
            pk = mPeak - PEAK_MARGIN;
            if (pk < 0) pk = 0;
            if (pk > avg) avg = pk;
`else
            pk = 0;
`endif
            if (avg > VOLT_MAX) avg = VOLT_MAX;
            mVolt = avg;
          end
          mCnt = 0; mAcc = 0; mSeen = 0; mPeak = 0;
        end else begin
          mCnt = mCnt + 1;
        end
      end
    end
    e.strobe = mStrobe;
    e.volt   = 8'(mVolt);
    e.stale  = mStale;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit sv, input int s, input bit es);
    @(negedge clk_sm);
    #1;
    rst          = r;
    sample_valid = sv;
    sample       = 8'(s);
    epoch_sync   = es;
    modelStep(r, sv, s, es);
    @(posedge clk_sm);
  endtask

  task automatic asyncReset();
    @(negedge clk_sm);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_volt", SM_voltage, 0);
    checkOutput("async_rst_valid", voltage_valid, 0);
    checkOutput("async_rst_stale", stale, 0);
    modelStep(1'b1, 1'b0, 0, 1'b0);
    @(posedge clk_sm);
  endtask

  always @(negedge clk_sm) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("strobe", voltage_valid, e.strobe);
      checkOutput("voltage", SM_voltage, e.volt);
      checkOutput("stale", stale, e.stale);
    end
  end

  initial begin
    #2;
    checkOutput("por_volt", SM_voltage, 0);
    checkOutput("por_valid", voltage_valid, 0);
    checkOutput("por_stale", stale, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);

    // Partial window, then reset pulled mid-cycle.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 100, 1'b0);
    asyncReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b1, 100, 1'b0);
    #1 checkOutput("const100", SM_voltage, 100);
    checkOutput("const100_stb", voltage_valid, 1);

    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b1, 255, 1'b0);
    #1 checkOutput("sat255", SM_voltage, 199);

    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b1, (i % 2) ? 31 : 10, 1'b0);
    #1 checkOutput("alt_floor", SM_voltage, 20);

    applyStimulus(1'b0, 1'b1, 60, 1'b0);
    for (int i = 1; i < WINDOW; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    #1 checkOutput("held60", SM_voltage, 60);
    checkOutput("held60_stale", stale, 0);
    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    #1 checkOutput("invalid_hold", SM_voltage, 60);
    checkOutput("invalid_stale", stale, 1);

    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 80, 1'b0);
    applyStimulus(1'b0, 1'b1, 80, 1'b1);
    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b1, 80, 1'b0);
    #1 checkOutput("epoch80", SM_voltage, 80);
    checkOutput("epoch80_stb", voltage_valid, 1);

    for (int i = 0; i < WINDOW - 1; i++) applyStimulus(1'b0, 1'b1, 90, 1'b0);
    applyStimulus(1'b0, 1'b1, 90, 1'b1);
    #1 checkOutput("epoch_last_nostb", voltage_valid, 0);
    checkOutput("epoch_last_volt", SM_voltage, 80);
    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b1, 90, 1'b0);

    for (int i = 0; i < WINDOW - 1; i++) applyStimulus(1'b0, 1'b1, 50, 1'b0);
    applyStimulus(1'b0, 1'b1, 200, 1'b0);
`ifdef VDM_PEAK_HOLD_EN
    #1 checkOutput("peak_hold", SM_voltage, 160);
`else
    #1 checkOutput("peak_avg", SM_voltage, 57);
`endif

    asyncReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < WINDOW; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    #1 checkOutput("rst_invalid_volt", SM_voltage, 0);
    checkOutput("rst_invalid_stale", stale, 1);

    for (int i = 0; i < 4 * WINDOW; i++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 255),
                    $urandom_range(0, 29) == 0);

    @(negedge clk_sm);
    #2;
    checkOutput("queue_drain", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
